ram_bist_master: RTL and testbench

RAM_BIST_MASTER -- requirements
Module: ram_bist_master

---
 rtl/ram_bist_pkg.sv | 39 +++
 rtl/ram_bist_pattern_gen.sv | 26 ++
 rtl/ram_bist_master.sv | 195 +++++++++++++++++++
 tb/tb_ram_bist_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared constants for the RAM BIST master: FSM encodings, pattern codes and
// per-RAM geometry (last address and data-width mask).
package ram_bist_pkg;

    localparam int ACK_TIMEOUT_DEF = 15;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WR_REQ = 3'd1;
    localparam state_t S_WR_GAP = 3'd2;
    localparam state_t S_RD_REQ = 3'd3;
    localparam state_t S_RD_GAP = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_ONES  = 2'd2;
    localparam logic [1:0] PAT_ZEROS = 2'd3;

    // RAM 0: 512x16, 1: 1024x16, 2: 1024x8, 3: 512x32
    function automatic logic [10:0] ram_last_adr(input logic [1:0] sel);
        case (sel)
            2'd0:    ram_last_adr = 11'd511;
            2'd1:    ram_last_adr = 11'd1023;
            2'd2:    ram_last_adr = 11'd1023;
            default: ram_last_adr = 11'd511;
        endcase
    endfunction

    function automatic logic [31:0] ram_dat_mask(input logic [1:0] sel);
        case (sel)
            2'd0:    ram_dat_mask = 32'h0000_FFFF;
            2'd1:    ram_dat_mask = 32'h0000_FFFF;
            2'd2:    ram_dat_mask = 32'h0000_00FF;
            default: ram_dat_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_pattern_gen.sv
// Combinational test-pattern source, masked to the selected RAM width; used
// both for write data and as the expected value on reads.
module ram_bist_pattern_gen
    import ram_bist_pkg::*;
(
    input  logic [10:0] adr_i,
    input  logic [1:0]  pat_i,
    input  logic [1:0]  ram_sel_i,
    output logic [31:0] dat_o
);

    logic [31:0] raw;

    always_comb begin
        // NOTE: every path assigns raw before use, so no latch is inferred.
        raw = '0;
        case (pat_i)
            PAT_ADDR:  raw = {21'd0, adr_i};
            PAT_CHECK: raw = adr_i[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            PAT_ONES:  raw = 32'hFFFF_FFFF;
            default:   raw = 32'h0000_0000;
        endcase
        dat_o = raw & ram_dat_mask(ram_sel_i);
    end

endmodule

// File: rtl/ram_bist_master.sv
// Wishbone-style BIST master: writes a pattern over the selected RAM, reads it
// back, counts miscompares and flags ACK timeouts. All outputs are registered.
module ram_bist_master
    import ram_bist_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic        start_i,
    input  logic [1:0]  ram_sel_i,
    input  logic [1:0]  pat_sel_i,
    output logic [10:0] WBs_ADR_o,
    output logic        WBs_RAM0_CYC_o,
    output logic        WBs_RAM1_CYC_o,
    output logic        WBs_RAM2_CYC_o,
    output logic        WBs_RAM3_CYC_o,
    output logic [3:0]  WBs_BYTE_STB_o,
    output logic        WBs_WE_o,
    output logic        WBs_STB_o,
    output logic [31:0] WBs_DAT_o,
    input  logic [31:0] WBs_RAM0_DAT_i,
    input  logic [31:0] WBs_RAM1_DAT_i,
    input  logic [31:0] WBs_RAM2_DAT_i,
    input  logic [31:0] WBs_RAM3_DAT_i,
    input  logic        WBs_ACK_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_cnt_o,
    output logic [10:0] first_err_adr_o
);

    state_t      state_q, state_d;
    logic [1:0]  ram_q, ram_d, pat_q, pat_d;
    logic [10:0] adr_q, adr_d, first_err_adr_q, first_err_adr_d;
    logic [15:0] tmo_q, tmo_d, err_cnt_q, err_cnt_d;
    logic [3:0]  cyc_q, cyc_d, bstb_q, bstb_d;
    logic        stb_q, stb_d, we_q, we_d;
    logic [31:0] dat_q, dat_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic        timeout_q, timeout_d;

    logic        start_ok, in_req, miscompare;
    logic [31:0] pat_dat, rd_dat;

    assign start_ok = (state_q == S_IDLE) && start_i;

    always_comb begin
        state_d   = state_q;
        ram_d     = ram_q;
        pat_d     = pat_q;
        adr_d     = adr_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d   = S_WR_REQ;
                ram_d     = ram_sel_i;
                pat_d     = pat_sel_i;
                adr_d     = '0;
                tmo_d     = '0;
                timeout_d = 1'b0;
            end
            S_WR_REQ, S_RD_REQ: begin
                if (WBs_ACK_i) begin
                    state_d = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
                end else if (tmo_q == 16'(ACK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WR_GAP, S_RD_GAP: begin
                tmo_d = '0;
                if (adr_q == ram_last_adr(ram_q)) begin
                    adr_d   = '0;
                    state_d = (state_q == S_WR_GAP) ? S_RD_REQ : S_DONE;
                end else begin
                    adr_d   = adr_q + 11'd1;
                    state_d = (state_q == S_WR_GAP) ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Fed with next-state values: this is next write data, and during RD_REQ
    // (address held) it is the expected read value.
    ram_bist_pattern_gen u_pat (
        .adr_i     (adr_d),
        .pat_i     (pat_d),
        .ram_sel_i (ram_d),
        .dat_o     (pat_dat)
    );

    always_comb begin
        case (ram_q)
            2'd0:    rd_dat = WBs_RAM0_DAT_i;
            2'd1:    rd_dat = WBs_RAM1_DAT_i;
            2'd2:    rd_dat = WBs_RAM2_DAT_i;
            default: rd_dat = WBs_RAM3_DAT_i;
        endcase
    end

    assign miscompare = (state_q == S_RD_REQ) && WBs_ACK_i &&
                        ((rd_dat & ram_dat_mask(ram_q)) != pat_dat);
    assign in_req     = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);

    always_comb begin
        err_cnt_d       = err_cnt_q;
        first_err_adr_d = first_err_adr_q;
        done_d          = done_q;
        pass_d          = pass_q;
        if (start_ok) begin
            err_cnt_d       = '0;
            first_err_adr_d = '0;
            done_d          = 1'b0;
            pass_d          = 1'b0;
        end else if (miscompare) begin
            if (err_cnt_q == 16'd0)     first_err_adr_d = adr_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == 16'd0) && !timeout_d;
        end
        cyc_d  = in_req ? (4'b0001 << ram_d) : 4'b0000;
        stb_d  = in_req;
        we_d   = (state_d == S_WR_REQ);
        bstb_d = in_req ? 4'hF : 4'h0;
        dat_d  = (state_d == S_WR_REQ) ? pat_dat : 32'd0;
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q         <= S_IDLE;
            ram_q           <= '0;
            pat_q           <= '0;
            adr_q           <= '0;
            tmo_q           <= '0;
            cyc_q           <= '0;
            stb_q           <= 1'b0;
            we_q            <= 1'b0;
            bstb_q          <= '0;
            dat_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
            err_cnt_q       <= '0;
            first_err_adr_q <= '0;
        end else begin
            state_q         <= state_d;
            ram_q           <= ram_d;
            pat_q           <= pat_d;
            adr_q           <= adr_d;
            tmo_q           <= tmo_d;
            cyc_q           <= cyc_d;
            stb_q           <= stb_d;
            we_q            <= we_d;
            bstb_q          <= bstb_d;
            dat_q           <= dat_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            timeout_q       <= timeout_d;
            err_cnt_q       <= err_cnt_d;
            first_err_adr_q <= first_err_adr_d;
        end
    end

    assign WBs_ADR_o       = adr_q;
    assign WBs_RAM0_CYC_o  = cyc_q[0];
    assign WBs_RAM1_CYC_o  = cyc_q[1];
    assign WBs_RAM2_CYC_o  = cyc_q[2];
    assign WBs_RAM3_CYC_o  = cyc_q[3];
    assign WBs_BYTE_STB_o  = bstb_q;
    assign WBs_WE_o        = we_q;
    assign WBs_STB_o       = stb_q;
    assign WBs_DAT_o       = dat_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = timeout_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_adr_o = first_err_adr_q;

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench for ram_bist_master with a behavioural RAM model that can
// withhold ACK, force a stuck bit, corrupt all reads and add upper-bit noise.
module tb_ram_bist_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  ram_sel = '0, pat_sel = '0;
    logic [10:0] adr, first_err_adr;
    logic        cyc0, cyc1, cyc2, cyc3, we, stb, ack;
    logic [3:0]  bstb;
    logic [31:0] dat_w;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        busy, done, pass, tmo;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // model controls
    logic        hold_w5 = 1'b0;
    logic        stuck_en = 1'b0;
    logic [31:0] flip_mask = '0;
    logic [1:0]  cur_ram = '0;
    logic [31:0] mem [0:1023];
    logic [31:0] rword, noise;
    int          wr_cnt = 0, rd_cnt = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  mon_allow = '0;
    logic        mon_bad = 1'b0;

    ram_bist_master dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .start_i(start),
        .ram_sel_i(ram_sel), .pat_sel_i(pat_sel),
        .WBs_ADR_o(adr),
        .WBs_RAM0_CYC_o(cyc0), .WBs_RAM1_CYC_o(cyc1),
        .WBs_RAM2_CYC_o(cyc2), .WBs_RAM3_CYC_o(cyc3),
        .WBs_BYTE_STB_o(bstb), .WBs_WE_o(we), .WBs_STB_o(stb),
        .WBs_DAT_o(dat_w),
        .WBs_RAM0_DAT_i(rd0), .WBs_RAM1_DAT_i(rd1),
        .WBs_RAM2_DAT_i(rd2), .WBs_RAM3_DAT_i(rd3),
        .WBs_ACK_i(ack),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_cnt_o(err_cnt), .first_err_adr_o(first_err_adr)
    );

    always #5 clk = ~clk;

    // RAM model: single-cycle ACK one clock after STB rises
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= (cyc0 | cyc1 | cyc2 | cyc3) && stb && !ack &&
                   !(hold_w5 && we && adr == 11'd5);
            if (ack && we) mem[adr[9:0]] <= dat_w;
            if (ack && stb) begin
                if (we) wr_cnt <= wr_cnt + 1;
                else    rd_cnt <= rd_cnt + 1;
            end
        end
    end

    always_comb begin
        noise = (cur_ram == 2'd2) ? 32'hFFFF_FF00 :
                (cur_ram == 2'd3) ? 32'h0000_0000 : 32'hFFFF_0000;
        rword = mem[adr[9:0]] ^ flip_mask ^ noise;
        // bit 1 is used: even-address checkerboard byte 0x55 already has bit 0 set
        if (stuck_en && adr == 11'd4) rword[1] = 1'b1;
        rd0 = cyc0 ? rword : 32'hDEAD_BEEF;
        rd1 = cyc1 ? rword : 32'hDEAD_BEEF;
        rd2 = cyc2 ? rword : 32'hDEAD_BEEF;
        rd3 = cyc3 ? rword : 32'hDEAD_BEEF;
    end

    always @(negedge clk)
        if (mon_en && (({cyc3, cyc2, cyc1, cyc0} & ~mon_allow) != 4'd0)) mon_bad = 1'b1;

    task automatic start_run(input logic [1:0] r, input logic [1:0] p);
        @(negedge clk);
        @(negedge clk);
        cur_ram = r;
        wr_cnt  = 0;
        rd_cnt  = 0;
        ram_sel = r;
        pat_sel = p;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_wait: done_o never rose within 20000 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({adr, cyc0, cyc1, cyc2, cyc3, bstb, we, stb, dat_w, busy, done, pass, tmo,
             err_cnt, first_err_adr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (adr=%h stb=%b err=%h)",
                     adr, stb, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_address_pass();
        start_run(2'd0, 2'd0);
        checks++;
        if (busy !== 1'b1 || cyc0 !== 1'b1 || bstb !== 4'hF || we !== 1'b1) begin
            errors++;
            $display("FAIL first_write: busy=%b cyc0=%b bstb=%h we=%b, expected 1 1 f 1",
                     busy, cyc0, bstb, we);
        end
        wait_done("addr");
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL addr_pass: pass=%b err=%h tmo=%b, expected 1 0000 0", pass, err_cnt, tmo);
        end
        checks++;
        if (wr_cnt != 512 || rd_cnt != 512) begin
            errors++;
            $display("FAIL addr_counts: writes=%0d reads=%0d, expected 512 512", wr_cnt, rd_cnt);
        end
        checks++;
        if (mem[300] !== 32'h0000_012C || mem[511] !== 32'h0000_01FF) begin
            errors++;
            $display("FAIL addr_data: mem[300]=%h mem[511]=%h, expected 0000012c 000001ff",
                     mem[300], mem[511]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || stb !== 1'b0) begin
            errors++;
            $display("FAIL status_persist: done=%b busy=%b stb=%b, expected 1 0 0", done, busy, stb);
        end
    endtask

    task automatic test_stuck_bit();
        stuck_en = 1'b1;
        start_run(2'd2, 2'd1);
        wait_done("stuck");
        stuck_en = 1'b0;
        checks++;
        if (err_cnt !== 16'd1 || first_err_adr !== 11'h004 || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck_bit: err=%h first=%h pass=%b, expected 0001 004 0",
                     err_cnt, first_err_adr, pass);
        end
        checks++;
        if (mem[4] !== 32'h0000_0055 || mem[5] !== 32'h0000_00AA || wr_cnt != 1024) begin
            errors++;
            $display("FAIL checker_data: mem4=%h mem5=%h writes=%0d, expected 55 aa 1024",
                     mem[4], mem[5], wr_cnt);
        end
    endtask

    task automatic test_err_count();
        flip_mask = 32'h8000_0000;
        start_run(2'd3, 2'd3);
        wait_done("errcnt");
        flip_mask = '0;
        checks++;
        if (err_cnt !== 16'd512 || first_err_adr !== 11'h000 || pass !== 1'b0) begin
            errors++;
            $display("FAIL err_count: err=%h first=%h pass=%b, expected 0200 000 0",
                     err_cnt, first_err_adr, pass);
        end
    endtask

    // A single run has only 512 reads; the counter is preloaded near the top
    // to stand in for a 70000-read run that must saturate.
    task automatic test_saturate();
        bit reached = 1'b0;
        flip_mask = 32'h0000_0001;
        start_run(2'd3, 2'd2);
        for (int i = 0; i < 5000 && !reached; i++) begin
            @(negedge clk);
            if (rd_cnt >= 3) reached = 1'b1;
        end
        force dut.err_cnt_q = 16'hFFF0;
        @(negedge clk);
        release dut.err_cnt_q;
        wait_done("sat");
        flip_mask = '0;
        checks++;
        if (err_cnt !== 16'hFFFF || first_err_adr !== 11'h000 || pass !== 1'b0) begin
            errors++;
            $display("FAIL saturate: err=%h first=%h pass=%b, expected ffff 000 0",
                     err_cnt, first_err_adr, pass);
        end
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        int cnt = 0;
        hold_w5 = 1'b1;
        start_run(2'd0, 2'd0);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (stb && we && adr == 11'd5) found = 1'b1;
        end
        while (stb && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        hold_w5 = 1'b0;
        checks++;
        if (!found || cnt != 15) begin
            errors++;
            $display("FAIL timeout_len: found=%b stb_cycles=%0d, expected 1 15", found, cnt);
        end
        checks++;
        if (tmo !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || stb !== 1'b0 || cyc0 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: tmo=%b done=%b pass=%b stb=%b cyc0=%b, expected 1 1 0 0 0",
                     tmo, done, pass, stb, cyc0);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        start_run(2'd1, 2'd1);
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (stb && !we && cyc1) found = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!found || {adr, cyc0, cyc1, cyc2, cyc3, bstb, we, stb, dat_w, busy, done, pass,
                       tmo, err_cnt, first_err_adr} !== '0) begin
            errors++;
            $display("FAIL async_reset: found=%b stb=%b cyc1=%b busy=%b, expected 1 0 0 0",
                     found, stb, cyc1, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        start_run(2'd1, 2'd0);
        wait_done("rerun");
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0 || rd_cnt != 1024) begin
            errors++;
            $display("FAIL reset_rerun: pass=%b err=%h reads=%0d, expected 1 0000 1024",
                     pass, err_cnt, rd_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        mon_allow = 4'b0001;
        mon_bad   = 1'b0;
        mon_en    = 1'b1;
        start_run(2'd0, 2'd3);
        for (int k = 0; k < 3; k++) begin
            repeat (100) @(negedge clk);
            ram_sel = 2'd3;
            pat_sel = 2'd2;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
        end
        wait_done("busy");
        mon_en = 1'b0;
        checks++;
        if (mon_bad !== 1'b0 || wr_cnt != 512 || rd_cnt != 512 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: bad_cyc=%b writes=%0d reads=%0d pass=%b, expected 0 512 512 1",
                     mon_bad, wr_cnt, rd_cnt, pass);
        end
        checks++;
        if (mem[7] !== 32'h0 || mem[300] !== 32'h0) begin
            errors++;
            $display("FAIL busy_data: mem7=%h mem300=%h, expected 0 0", mem[7], mem[300]);
        end
    endtask

    initial begin
        test_reset();
        test_address_pass();
        test_stuck_bit();
        test_err_count();
        test_saturate();
        test_timeout();
        test_async_reset();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
